abft_row_checker: RTL and testbench
===================================

Name: abft_row_checker

Overview:
- Checks each row of C for algorithm-based fault tolerance (ABFT) errors, directly downstream of the matrix-multiply FSM/MAC datapath.
- Consumes each C row as a stream of N data elements followed by one checksum element, produced by the extra checksum column of B.
- Flags rows whose element sum mismatches the checksum and records up to two faulty row indices. The FSM uses these to enter its Correct1/Correct2 recompute passes.

Parameters:
- DATA_W, 32, width of one C element and of the checksum.
- N, 4, data elements per row (checksum beat excluded).
- ROWS, 4, rows per matrix.
- MAX_FAULTS, 2, number of fault-table entries; equals the number of correction passes.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous active-high reset.
- frame_start  in  1  one-cycle pulse; clears row counter, fault table and status for a new matrix.
- in_valid  in  1  element valid.
- in_ready  out  1  element accepted when in_valid && in_ready.
- in_data  in  DATA_W  C element, or checksum on the last beat of a row.
- row_done  out  1  one-cycle pulse after each row check.
- row_err  out  1  qualified by row_done; 1 means mismatch.
- row_idx  out  $clog2(ROWS)  index of the row just checked.
- matrix_done  out  1  one-cycle pulse when row ROWS-1 has been reported.
- fault_cnt  out  $clog2(MAX_FAULTS+1)  saturating count of recorded faulty rows.
- fault_row0/fault_row1  out  $clog2(ROWS) each  recorded faulty row indices, in detection order.
- fault_ovf  out  1  sticky; set when more than MAX_FAULTS faulty rows are seen.

Behaviour:
- Reset values: state S_IDLE; in_ready, row_done, row_err, matrix_done and fault_ovf = 0; row_idx, fault_cnt and fault_row* = 0.
- S_IDLE:
  - in_ready=0.
  - frame_start → S_ACC; clears col counter, row counter, accumulator, fault table, fault_cnt and fault_ovf.
- S_ACC:
  - in_ready=1.
  - Each accepted beat with col<N: acc <= acc + in_data, modulo 2^DATA_W (wrap; no carry kept). Then col++.
  - Accepted beat with col==N: latch in_data as chk; in_ready drops next cycle; → S_CHK.
  - Gaps in in_valid are allowed; acc and col hold.
- S_CHK (1 cycle): mismatch <= (acc != chk) → S_REPORT.
- S_REPORT (1 cycle):
  - row_done=1, row_err=mismatch, row_idx=row counter.
  - If mismatch and fault_cnt<MAX_FAULTS: write fault_row[fault_cnt], then fault_cnt++.
  - If mismatch and the table is full: fault_ovf<=1; fault_cnt holds.
  - Clear acc and col.
  - Not last row: row++ → S_ACC.
  - Last row: matrix_done=1 in the same cycle → S_IDLE.
- Latency: row_done is asserted 2 cycles after the cycle the checksum beat is accepted.
- Throughput: N+1 beats per row plus 2 bubble cycles.
- frame_start while not in S_IDLE:
  - Aborts the current matrix; all clears are applied; → S_ACC next cycle.
  - The partial row is discarded and no row_done is issued.
  - frame_start has priority over every other event in the same cycle.
- rst mid-row: returns to reset values next edge; no pulses are issued.
- fault_cnt, fault_row* and fault_ovf hold after matrix_done until the next frame_start. The FSM samples them in IDLE.
- Checksum equality is exact on all DATA_W bits. Overflow wrap is identical on both sides, so it is not an error.

Decomposition:
- Shared package abft_pkg:
  - typedef enum for checker states (S_IDLE, S_ACC, S_CHK, S_REPORT), one-hot, matching the FSM's one-hot encoding style.
  - localparams DATA_W, N, ROWS, MAX_FAULTS, shared with the FSM and RAM top.
- One natural sub-module: abft_fault_table, holding the MAX_FAULTS index registers, saturating count and overflow flag; its write port is driven from S_REPORT.

Test Plan:
- Clean matrix:
  - Stimulus: 4 rows of [1,2,3,4 | 10] → 4 row_done pulses with row_err=0.
  - Required: matrix_done on the 4th report; fault_cnt=0; fault_ovf=0.
- Single fault:
  - Stimulus: row 2 = [5,6,7,9 | 26], others clean.
  - Required: row_err=1 only at row_idx=2; fault_cnt=1; fault_row0=2.
- Two faults, then overflow:
  - Stimulus: rows 0, 1 and 3 corrupted.
  - Required: fault_row0=0, fault_row1=1, fault_cnt=2, fault_ovf=1.
- Wrap arithmetic:
  - Stimulus: row [FFFFFFFF,1,0,2 | 2].
  - Required: row_err=0.
- Backpressure and gaps:
  - Stimulus: random in_valid gaps; checksum beat accepted at cycle t.
  - Required: row_done at t+2; in_ready=0 in the 2 cycles after the checksum beat.
- Abort:
  - Stimulus: frame_start after 2 beats of row 1.
  - Required: no row_done for the aborted row; the next row is reported as row_idx=0; fault table cleared.

Source files
------------

// File: rtl/abft_pkg.sv
// rtl/abft_pkg.sv - shared ABFT checker parameters and state encoding
package abft_pkg;
    localparam int DATA_W     = 32;
    localparam int N          = 4;
    localparam int ROWS       = 4;
    localparam int MAX_FAULTS = 2;

    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(N + 1);
    localparam int CNT_W = $clog2(MAX_FAULTS + 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'b0001,
        S_ACC    = 4'b0010,
        S_CHK    = 4'b0100,
        S_REPORT = 4'b1000
    } chk_state_e;
endpackage

// File: rtl/abft_fault_table.sv
// rtl/abft_fault_table.sv - faulty-row index table with saturating count and sticky overflow
module abft_fault_table
    import abft_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr_en,
    input  logic [ROW_W-1:0] wr_row,
    output logic [CNT_W-1:0] fault_cnt,
    output logic [ROW_W-1:0] fault_row0,
    output logic [ROW_W-1:0] fault_row1,
    output logic             fault_ovf
);
    logic [ROW_W-1:0] rows_q [MAX_FAULTS];
    logic [CNT_W-1:0] cnt_q;
    logic             ovf_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < MAX_FAULTS; i++) rows_q[i] <= '0;
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else if (wr_en) begin
            // Once full, further faults only raise the overflow flag.
            if (cnt_q < CNT_W'(MAX_FAULTS)) begin
                for (int i = 0; i < MAX_FAULTS; i++) begin
                    if (cnt_q == CNT_W'(i)) rows_q[i] <= wr_row;
                end
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                ovf_q <= 1'b1;
            end
        end
    end

    assign fault_cnt  = cnt_q;
    assign fault_row0 = rows_q[0];
    assign fault_row1 = rows_q[1];
    assign fault_ovf  = ovf_q;
endmodule

// File: rtl/abft_row_checker.sv
// rtl/abft_row_checker.sv - per-row checksum check of C rows with fault recording
module abft_row_checker
    import abft_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              row_done,
    output logic              row_err,
    output logic [ROW_W-1:0]  row_idx,
    output logic              matrix_done,
    output logic [CNT_W-1:0]  fault_cnt,
    output logic [ROW_W-1:0]  fault_row0,
    output logic [ROW_W-1:0]  fault_row1,
    output logic              fault_ovf
);
    chk_state_e        state_q, state_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [DATA_W-1:0] chk_q, chk_d;
    logic              mismatch_q, mismatch_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            col_q      <= '0;
            row_q      <= '0;
            acc_q      <= '0;
            chk_q      <= '0;
            mismatch_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            row_q      <= row_d;
            acc_q      <= acc_d;
            chk_q      <= chk_d;
            mismatch_q <= mismatch_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        col_d       = col_q;
        row_d       = row_q;
        acc_d       = acc_q;
        chk_d       = chk_q;
        mismatch_d  = mismatch_q;
        in_ready    = (state_q == S_ACC);
        // A new frame pre-empts a report landing in the same cycle.
        row_done    = (state_q == S_REPORT) && !frame_start;
        row_err     = row_done && mismatch_q;
        matrix_done = row_done && (row_q == ROW_W'(ROWS - 1));
        row_idx     = row_q;

        if (frame_start) begin
            state_d = S_ACC;
            col_d   = '0;
            row_d   = '0;
            acc_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: ;
                S_ACC: begin
                    if (in_valid) begin
                        if (col_q == COL_W'(N)) begin
                            chk_d   = in_data;
                            state_d = S_CHK;
                        end else begin
                            acc_d = acc_q + in_data;
                            col_d = col_q + COL_W'(1);
                        end
                    end
                end
                S_CHK: begin
                    mismatch_d = (acc_q != chk_q);
                    state_d    = S_REPORT;
                end
                S_REPORT: begin
                    acc_d = '0;
                    col_d = '0;
                    if (row_q == ROW_W'(ROWS - 1)) begin
                        state_d = S_IDLE;
                    end else begin
                        row_d   = row_q + ROW_W'(1);
                        state_d = S_ACC;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    abft_fault_table u_fault_table (
        .clk        (clk),
        .rst        (rst),
        .clr        (frame_start),
        .wr_en      (row_err),
        .wr_row     (row_q),
        .fault_cnt  (fault_cnt),
        .fault_row0 (fault_row0),
        .fault_row1 (fault_row1),
        .fault_ovf  (fault_ovf)
    );
endmodule

// File: tb/tb_abft_row_checker.sv
// tb/tb_abft_row_checker.sv - randomized self-checking bench for abft_row_checker
module tb_abft_row_checker;
    import abft_pkg::*;

    logic              clk = 1'b0;
    logic              rst;
    logic              frame_start;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              row_done;
    logic              row_err;
    logic [ROW_W-1:0]  row_idx;
    logic              matrix_done;
    logic [CNT_W-1:0]  fault_cnt;
    logic [ROW_W-1:0]  fault_row0;
    logic [ROW_W-1:0]  fault_row1;
    logic              fault_ovf;

    int n_checks = 0;
    int n_errors = 0;
    bit mon_en   = 1'b0;

    always #5 clk = ~clk;

    abft_row_checker dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .row_done    (row_done),
        .row_err     (row_err),
        .row_idx     (row_idx),
        .matrix_done (matrix_done),
        .fault_cnt   (fault_cnt),
        .fault_row0  (fault_row0),
        .fault_row1  (fault_row1),
        .fault_ovf   (fault_ovf)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: transaction-level view of rows, reports and the fault list.
    int          cyc = 0;
    int          rdy_from = 0;
    int          rdy_until = -1;
    int          m_row = 0;
    logic [31:0] beats[$];
    int          pend_due[$];
    int          pend_err[$];
    int          pend_idx[$];
    int          flt[$];
    bit          m_ovf = 1'b0;
    bit          exp_rdy;
    bit          exp_done;
    logic [31:0] m_sum;

    task automatic model_reset();
        beats.delete();
        pend_due.delete();
        pend_err.delete();
        pend_idx.delete();
        flt.delete();
        m_ovf     = 1'b0;
        m_row     = 0;
        rdy_from  = 0;
        rdy_until = -1;
    endtask

    always @(negedge clk) begin
        cyc++;
        if (rst) begin
            model_reset();
        end else if (mon_en) begin
            exp_rdy  = (cyc >= rdy_from) && (cyc <= rdy_until);
            exp_done = (pend_due.size() > 0) && (pend_due[0] == cyc) && !frame_start;
            check_val("in_ready", in_ready, exp_rdy);
            check_val("row_done", row_done, exp_done);
            if (exp_done) begin
                check_val("row_err", row_err, pend_err[0]);
                check_val("row_idx", row_idx, pend_idx[0]);
                check_val("matrix_done", matrix_done, pend_idx[0] == ROWS - 1);
            end else begin
                check_val("matrix_done_idle", matrix_done, 0);
            end
            check_val("fault_cnt", fault_cnt, flt.size());
            check_val("fault_row0", fault_row0, flt.size() > 0 ? flt[0] : 0);
            check_val("fault_row1", fault_row1, flt.size() > 1 ? flt[1] : 0);
            check_val("fault_ovf", fault_ovf, m_ovf);

            if (frame_start) begin
                model_reset();
                rdy_from  = cyc + 1;
                rdy_until = 32'h7fff_ffff;
            end else begin
                if ((pend_due.size() > 0) && (pend_due[0] == cyc)) begin
                    if (pend_err[0] != 0) begin
                        if (flt.size() < MAX_FAULTS) flt.push_back(pend_idx[0]);
                        else m_ovf = 1'b1;
                    end
                    void'(pend_due.pop_front());
                    void'(pend_err.pop_front());
                    void'(pend_idx.pop_front());
                end
                if (in_valid && exp_rdy) begin
                    beats.push_back(in_data);
                    if (beats.size() == N + 1) begin
                        m_sum = '0;
                        for (int i = 0; i < N; i++) m_sum += beats[i];
                        pend_due.push_back(cyc + 2);
                        pend_err.push_back(m_sum != beats[N] ? 1 : 0);
                        pend_idx.push_back(m_row);
                        beats.delete();
                        if (m_row == ROWS - 1) begin
                            rdy_until = cyc;
                            m_row     = 0;
                        end else begin
                            rdy_from = cyc + 3;
                            m_row++;
                        end
                    end
                end
            end
        end
    end

    logic [31:0] row_buf [N];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        in_valid    = 1'b0;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic send_beat(input logic [31:0] d, input int gap_pct);
        int  waited;
        bit  acc;
        while ($urandom_range(99) < gap_pct) begin
            in_valid = 1'b0;
            tick();
        end
        in_valid = 1'b1;
        in_data  = d;
        waited   = 0;
        do begin
            acc = in_ready;
            tick();
            waited++;
        end while (!acc && waited < 20);
        if (!acc) check_val("beat_accept_timeout", 0, 1);
        in_valid = 1'b0;
    endtask

    task automatic set_row(input logic [31:0] a, b, c, d);
        row_buf[0] = a;
        row_buf[1] = b;
        row_buf[2] = c;
        row_buf[3] = d;
    endtask

    task automatic rand_row();
        for (int i = 0; i < N; i++) row_buf[i] = $urandom;
    endtask

    function automatic logic [31:0] row_sum();
        logic [31:0] s = '0;
        for (int i = 0; i < N; i++) s += row_buf[i];
        return s;
    endfunction

    task automatic send_row(input logic [31:0] chk, input int gap_pct);
        for (int i = 0; i < N; i++) send_beat(row_buf[i], gap_pct);
        send_beat(chk, gap_pct);
    endtask

    task automatic wait_matrix_done();
        int k = 0;
        while (!matrix_done && k < 10) begin
            tick();
            k++;
        end
        if (!matrix_done) check_val("matrix_done_timeout", 0, 1);
        tick();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c;
        int          gap;
        rst         = 1'b1;
        frame_start = 1'b0;
        in_valid    = 1'b0;
        in_data     = '0;
        repeat (3) tick();
        rst = 1'b0;
        check_val("rst_in_ready", in_ready, 0);
        check_val("rst_row_done", row_done, 0);
        check_val("rst_matrix_done", matrix_done, 0);
        check_val("rst_fault_cnt", fault_cnt, 0);
        check_val("rst_fault_ovf", fault_ovf, 0);
        check_val("rst_row_idx", row_idx, 0);
        mon_en = 1'b1;
        tick();

        pulse_start();
        for (int r = 0; r < ROWS; r++) begin
            set_row(1, 2, 3, 4);
            send_row(10, 20);
        end
        wait_matrix_done();
        check_val("clean_fault_cnt", fault_cnt, 0);
        check_val("clean_fault_ovf", fault_ovf, 0);

        pulse_start();
        for (int r = 0; r < ROWS; r++) begin
            if (r == 2) begin
                set_row(5, 6, 7, 9);
                send_row(26, 20);
            end else begin
                set_row(1, 2, 3, 4);
                send_row(10, 20);
            end
        end
        wait_matrix_done();
        check_val("single_fault_cnt", fault_cnt, 1);
        check_val("single_fault_row0", fault_row0, 2);

        pulse_start();
        for (int r = 0; r < ROWS; r++) begin
            rand_row();
            c = row_sum();
            if (r != 2) c = c ^ (32'h1 << $urandom_range(31));
            send_row(c, 30);
        end
        wait_matrix_done();
        check_val("ovf_fault_row0", fault_row0, 0);
        check_val("ovf_fault_row1", fault_row1, 1);
        check_val("ovf_fault_cnt", fault_cnt, 2);
        check_val("ovf_fault_ovf", fault_ovf, 1);

        pulse_start();
        set_row(32'hFFFF_FFFF, 1, 0, 2);
        send_row(2, 0);
        for (int r = 1; r < ROWS; r++) begin
            rand_row();
            send_row(row_sum(), 0);
        end
        wait_matrix_done();
        check_val("wrap_fault_cnt", fault_cnt, 0);

        for (int m = 0; m < 20; m++) begin
            gap = $urandom_range(60);
            pulse_start();
            for (int r = 0; r < ROWS; r++) begin
                rand_row();
                c = row_sum();
                if ($urandom_range(99) < 40) c = c + $urandom_range(1, 65535);
                send_row(c, gap);
            end
            wait_matrix_done();
            repeat ($urandom_range(3)) tick();
        end

        pulse_start();
        rand_row();
        send_row(row_sum() + 32'd7, 10);
        rand_row();
        send_beat(row_buf[0], 10);
        send_beat(row_buf[1], 10);
        check_val("abort_pre_fault_cnt", fault_cnt, 1);
        pulse_start();
        check_val("abort_post_fault_cnt", fault_cnt, 0);
        for (int r = 0; r < ROWS; r++) begin
            rand_row();
            send_row(row_sum(), 25);
        end
        wait_matrix_done();
        check_val("abort_final_fault_cnt", fault_cnt, 0);

        pulse_start();
        rand_row();
        send_row(row_sum() ^ 32'h8000_0000, 0);
        rand_row();
        for (int i = 0; i < 3; i++) send_beat(row_buf[i], 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("midrst_in_ready", in_ready, 0);
        check_val("midrst_fault_cnt", fault_cnt, 0);
        check_val("midrst_row_done", row_done, 0);
        tick();

        pulse_start();
        for (int r = 0; r < ROWS; r++) begin
            rand_row();
            send_row(row_sum(), 15);
        end
        wait_matrix_done();
        repeat (3) tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
